// File: rtl/ifu_pipe.sv
// Instruction fetch unit: PC register, combinational ROM address, IF/ID stage
// register with stall/flush, three redirect modes, address-error flag, fetch counter.
module ifu_pipe #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_AW    = 10,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             redirect_valid,
  input  logic [1:0]       redirect_mode,
  input  logic [31:0]      redirect_base,
  input  logic [31:0]      redirect_offset,
  input  logic [25:0]      redirect_index,
  input  logic [31:0]      redirect_reg,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_pc_plus8,
  output logic             if_valid,
  output logic             if_exc,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    RD_BRANCH = 2'd0,
    RD_JUMP   = 2'd1,
    RD_REG    = 2'd2,
    RD_NONE   = 2'd3
  } rd_mode_e;

  typedef struct packed {
    logic        valid;
    logic        exc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
  } ifid_t;

  // One past the last byte of the window; 33 bits so the bound cannot wrap.
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + (33'd4 << IM_AW);

  logic [31:0]      pc_q, pc_d;
  ifid_t            ifid_q, ifid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] pc_off;
  logic        addr_err;
  logic [31:0] base_plus4;
  logic [31:0] tgt;
  logic        tgt_ok;
  logic        unused_off;

  assign pc_off     = pc_q - RESET_PC;
  assign im_addr    = pc_off[IM_AW+1:2];
  assign unused_off = ^{pc_off[31:IM_AW+2], pc_off[1:0]};

  assign addr_err = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) ||
                    ({1'b0, pc_q} >= PC_LIMIT);

  always_comb begin
    base_plus4 = redirect_base + 32'd4;
    tgt        = pc_q + 32'd4;
    tgt_ok     = 1'b1;
    case (rd_mode_e'(redirect_mode))
      RD_BRANCH: tgt = base_plus4 + redirect_offset;
      RD_JUMP:   tgt = {base_plus4[31:28], redirect_index, 2'b00};
      RD_REG:    tgt = redirect_reg;
      default:   tgt_ok = 1'b0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (!stall) begin
      if (redirect_valid && tgt_ok) pc_d = tgt;
      else                          pc_d = pc_q + 32'd4;
    end
  end

  // Flush wins over stall so a squash can be injected while the front end is held.
  always_comb begin
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    if (flush) begin
      ifid_d = '0;
    end else if (!stall) begin
      ifid_d.valid    = 1'b1;
      ifid_d.exc      = addr_err;
      ifid_d.instr    = addr_err ? 32'h0 : im_rdata;
      ifid_d.pc       = pc_q;
      ifid_d.pc_plus8 = pc_q + 32'd8;
      cnt_d           = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      ifid_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign if_instr    = ifid_q.instr;
  assign if_pc       = ifid_q.pc;
  assign if_pc_plus8 = ifid_q.pc_plus8;
  assign if_valid    = ifid_q.valid;
  assign if_exc      = ifid_q.exc;
  assign fetch_count = cnt_q;

endmodule
